// File: rtl/vlane_div_pkg.sv
// rtl/vlane_div_pkg.sv - shared constants for the vector-lane divider
// Purpose: FSM state encodings and op-field bit positions used by vlane_divider.
// Ports: none (package).
package vlane_div_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ITER = 2'd1;
  localparam state_t ST_FIX  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  // Bit positions within the 2-bit op field
  localparam int OP_UNSIGNED = 0;
  localparam int OP_REM      = 1;

endpackage

// File: rtl/vlane_div_step.sv
// rtl/vlane_div_step.sv - one combinational restoring-division step
// Purpose: shift {rem,quo} left by one, trial-subtract the divisor from the
//   partial remainder, keep the difference and set the quotient LSB when no
//   borrow occurs.
// Ports:
//   rem_in   [WIDTH:0]   partial remainder before the step
//   quo_in   [WIDTH-1:0] partial quotient / remaining dividend bits
//   divisor  [WIDTH-1:0] divisor magnitude
//   rem_out  [WIDTH:0]   partial remainder after the step
//   quo_out  [WIDTH-1:0] partial quotient after the step
module vlane_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             borrow;

  // The remainder is always below the divisor, so its top bit is zero on
  // entry; the extra bit only matters after the shift.
  logic unused_rem_msb;
  assign unused_rem_msb = rem_in[WIDTH];

  always_comb begin
    shifted = {rem_in[WIDTH-1:0], quo_in[WIDTH-1]};
    trial   = {1'b0, shifted} - {2'b00, divisor};
    borrow  = trial[WIDTH+1];
    if (borrow) begin
      rem_out = shifted;
      quo_out = {quo_in[WIDTH-2:0], 1'b0};
    end else begin
      rem_out = trial[WIDTH:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/vlane_divider.sv
// rtl/vlane_divider.sv - iterative signed/unsigned restoring divider
// Purpose: fixed-latency DIV/DIVU/REM/REMU for the vector lane, one quotient
//   bit per cycle, valid/ready handshakes on input and output.
// Ports:
//   clk, resetn           clock, asynchronous active-low reset
//   opA, opB [WIDTH-1:0]  dividend, divisor
//   op [1:0]              bit0 unsigned, bit1 remainder
//   in_valid / in_ready   operation handshake
//   flush                 synchronous abort of the in-flight op
//   out_valid / out_ready result handshake
//   result [WIDTH-1:0]    quotient or remainder (registered)
module vlane_divider
  import vlane_div_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int LOG2WIDTH = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic [1:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);

  localparam logic [LOG2WIDTH-1:0] LAST_CNT = LOG2WIDTH'(WIDTH - 1);

  state_t               state_q, state_d;
  logic [LOG2WIDTH-1:0] count_q, count_d;
  logic [WIDTH:0]       rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     div_q, div_d;
  logic [WIDTH-1:0]     opa_q, opa_d;
  logic                 uns_q, uns_d;
  logic                 is_rem_q, is_rem_d;
  logic                 a_neg_q, a_neg_d;
  logic                 b_neg_q, b_neg_d;
  logic                 div_zero_q, div_zero_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     result_q, result_d;

  logic             accept;
  logic             a_neg_in, b_neg_in;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] q_fix, r_fix;

  assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_DONE && out_ready);
  assign accept    = in_valid && in_ready && !flush;
  assign out_valid = out_valid_q;
  assign result    = result_q;

  // Magnitudes of the incoming operands; the most negative value maps to
  // 2^(WIDTH-1), which is representable as an unsigned magnitude.
  assign a_neg_in = !op[OP_UNSIGNED] && opA[WIDTH-1];
  assign b_neg_in = !op[OP_UNSIGNED] && opB[WIDTH-1];
  assign a_mag    = a_neg_in ? (~opA + WIDTH'(1)) : opA;
  assign b_mag    = b_neg_in ? (~opB + WIDTH'(1)) : opB;

  vlane_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (div_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  // Sign fix-up; divide-by-zero bypasses it and reports raw dividend.
  always_comb begin
    q_fix = quo_q;
    r_fix = rem_q[WIDTH-1:0];
    if (!uns_q && (a_neg_q ^ b_neg_q)) q_fix = ~quo_q + WIDTH'(1);
    if (!uns_q && a_neg_q)             r_fix = ~rem_q[WIDTH-1:0] + WIDTH'(1);
    if (div_zero_q) begin
      q_fix = '1;
      r_fix = opa_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    div_d       = div_q;
    opa_d       = opa_q;
    uns_d       = uns_q;
    is_rem_d    = is_rem_q;
    a_neg_d     = a_neg_q;
    b_neg_d     = b_neg_q;
    div_zero_d  = div_zero_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;

    case (state_q)
      ST_ITER: begin
        rem_d   = step_rem;
        quo_d   = step_quo;
        count_d = count_q + LOG2WIDTH'(1);
        if (count_q == LAST_CNT) begin
          count_d = '0;
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        result_d    = is_rem_q ? r_fix : q_fix;
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: ;
    endcase

    // Acceptance is only possible from IDLE or from DONE while the result
    // is being taken, so it simply overrides the state-specific update.
    if (accept) begin
      state_d     = ST_ITER;
      count_d     = '0;
      rem_d       = '0;
      quo_d       = a_mag;
      div_d       = b_mag;
      opa_d       = opA;
      uns_d       = op[OP_UNSIGNED];
      is_rem_d    = op[OP_REM];
      a_neg_d     = a_neg_in;
      b_neg_d     = b_neg_in;
      div_zero_d  = (opB == '0);
      out_valid_d = 1'b0;
    end

    if (flush) begin
      state_d     = ST_IDLE;
      count_d     = '0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      div_q       <= '0;
      opa_q       <= '0;
      uns_q       <= 1'b0;
      is_rem_q    <= 1'b0;
      a_neg_q     <= 1'b0;
      b_neg_q     <= 1'b0;
      div_zero_q  <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      div_q       <= div_d;
      opa_q       <= opa_d;
      uns_q       <= uns_d;
      is_rem_q    <= is_rem_d;
      a_neg_q     <= a_neg_d;
      b_neg_q     <= b_neg_d;
      div_zero_q  <= div_zero_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
    end
  end

endmodule

// File: tb/tb_vlane_divider.sv
// tb/tb_vlane_divider.sv - self-checking bench for vlane_divider
module tb_vlane_divider;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic [1:0]   op_s = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         flush = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vlane_divider #(.WIDTH(W), .LOG2WIDTH(5)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .opA       (op_a),
    .opB       (op_b),
    .op        (op_s),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Independent reference using 64-bit native division
  function automatic logic [W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [1:0] o);
    longint sa, sb, q, r;
    if (b == '0) return o[1] ? a : '1;
    if (o[0]) begin
      sa = $signed({32'b0, a});
      sb = $signed({32'b0, b});
    end else begin
      sa = $signed({{32{a[W-1]}}, a});
      sb = $signed({{32{b[W-1]}}, b});
    end
    q = sa / sb;
    r = sa % sb;
    return o[1] ? r[W-1:0] : q[W-1:0];
  endfunction

  // Drive one op at a negedge; returns at the negedge after the accept edge
  // with the inputs scrambled so late sampling would be caught.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] o);
    @(negedge clk);
    op_a = a; op_b = b; op_s = o; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    op_a = ~a; op_b = ~b; op_s = ~o;
  endtask

  // Count edges after acceptance until out_valid is seen (bounded).
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] o, input logic [W-1:0] exp);
    int lat;
    issue(a, b, o);
    wait_valid(lat);
    check({name, "_res"}, result, exp);
    check({name, "_lat"}, W'(lat), W'(LAT));
    pop();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [W-1:0] r0;
    logic ok;
    logic [W-1:0] ra, rb;
    logic [1:0] ro;

    vecs[0]  = '{32'd100,        32'd7,          2'b01, 32'd14};
    vecs[1]  = '{32'd100,        32'd7,          2'b11, 32'd2};
    vecs[2]  = '{32'hFFFFFFF9,   32'd2,          2'b00, 32'hFFFFFFFD};
    vecs[3]  = '{32'hFFFFFFF9,   32'd2,          2'b10, 32'hFFFFFFFF};
    vecs[4]  = '{32'd7,          32'hFFFFFFFE,   2'b00, 32'hFFFFFFFD};
    vecs[5]  = '{32'd7,          32'hFFFFFFFE,   2'b10, 32'd1};
    vecs[6]  = '{32'd5,          32'd0,          2'b01, 32'hFFFFFFFF};
    vecs[7]  = '{32'd5,          32'd0,          2'b11, 32'd5};
    vecs[8]  = '{32'h80000000,   32'hFFFFFFFF,   2'b00, 32'h80000000};
    vecs[9]  = '{32'h80000000,   32'hFFFFFFFF,   2'b10, 32'd0};
    vecs[10] = '{32'hFFFFFFFF,   32'd1,          2'b01, 32'hFFFFFFFF};
    vecs[11] = '{32'hFFFFFFFB,   32'd0,          2'b10, 32'hFFFFFFFB};
    vecs[12] = '{32'hFFFFFFFB,   32'd0,          2'b00, 32'hFFFFFFFF};
    vecs[13] = '{32'h80000000,   32'hFFFFFFFF,   2'b11, 32'h80000000};
    vecs[14] = '{32'hFFFFFF9C,   32'hFFFFFFF9,   2'b00, 32'd14};
    vecs[15] = '{32'hFFFFFF9C,   32'hFFFFFFF9,   2'b10, 32'hFFFFFFFE};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready",  W'(in_ready),  W'(1));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_result",    result,        '0);
    resetn = 1'b1;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 16; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp);

    // Backpressure: result held 10 cycles, then pop + accept in one cycle
    issue(32'd1000, 32'd10, 2'b01);
    wait_valid(lat);
    check("bp_lat", W'(lat), W'(LAT));
    r0 = result;
    check("bp_res", r0, 32'd100);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (result !== r0 || in_ready !== 1'b0 || out_valid !== 1'b1) ok = 1'b0;
    end
    check("bp_hold", W'(ok), W'(1));
    out_ready = 1'b1; in_valid = 1'b1;
    op_a = 32'hFFFFFFF9; op_b = 32'd2; op_s = 2'b00;
    #1;
    check("bp_in_ready", W'(in_ready), W'(1));
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    op_a = '0; op_b = '0; op_s = 2'b11;
    check("bp_valid_drop", W'(out_valid), W'(0));
    wait_valid(lat);
    check("bp2_lat", W'(lat), W'(LAT));
    check("bp2_res", result, 32'hFFFFFFFD);
    pop();

    // Flush at iteration count 15
    issue(32'd100, 32'd7, 2'b01);
    repeat (15) @(negedge clk);
    flush = 1'b1; in_valid = 1'b1;
    op_a = 32'd50; op_b = 32'd5; op_s = 2'b01;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("fl_out_valid", W'(out_valid), W'(0));
    check("fl_in_ready",  W'(in_ready),  W'(1));
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) ok = 1'b0;
    end
    check("fl_quiet", W'(ok), W'(1));
    run_op("fl_after", 32'd200, 32'd9, 2'b01, 32'd22);

    // Reset mid-iteration
    run_op("pre_rst", 32'd100, 32'd7, 2'b01, 32'd14);
    issue(32'd12345, 32'd67, 2'b01);
    repeat (10) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("mrst_in_ready",  W'(in_ready),  W'(1));
    check("mrst_out_valid", W'(out_valid), W'(0));
    check("mrst_result",    result,        '0);
    @(negedge clk);
    resetn = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) ok = 1'b0;
    end
    check("mrst_quiet", W'(ok), W'(1));

    // Random ops against the reference model
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case (i % 4)
        0: rb = $urandom;
        1: rb = W'($urandom_range(1, 300));
        2: rb = -W'($urandom_range(1, 300));
        default: rb = (i % 8 == 3) ? '0 : W'($urandom_range(1, 65535));
      endcase
      ro = 2'(i % 4);
      run_op($sformatf("rnd%0d", i), ra, rb, ro, ref_div(ra, rb, ro));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vlane_divider.md
# vlane_divider

Iterative integer divider for the vector lane, complementing the lane's multiply/shift unit: where that unit produces products and shifts, this block produces quotient or remainder. Signed or unsigned WIDTH-bit restoring division, one quotient bit per cycle, with fixed latency and valid/ready handshakes on both sides. It sits beside the multiplier in the lane's execute stage and is shared by DIV/DIVU/REM/REMU instructions.

## Interface
- WIDTH, 32, operand/result width (even, ≥4)
- LOG2WIDTH, 5, width of iteration counter (2^LOG2WIDTH ≥ WIDTH)
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- opA  in  WIDTH  dividend
- opB  in  WIDTH  divisor
- op  in  2  op[0]=1 unsigned / 0 signed; op[1]=1 remainder / 0 quotient
- in_valid  in  1  operands/op valid
- in_ready  out  1  block can accept an operation this cycle
- flush  in  1  synchronous abort of in-flight op
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result this cycle
- result  out  WIDTH  quotient or remainder

## Operation
- States: IDLE, ITER, FIX, DONE.
- Accept when in_valid && in_ready: latch op, sign flags, |opA| and |opB| (magnitude only when signed; MIN magnitude = 2^(WIDTH-1) unsigned), clear partial remainder, count=0, flag div_zero=(opB==0); go ITER.
- ITER: per cycle shift {rem,quo} left 1, trial-subtract divisor magnitude from rem; if no borrow keep difference and set quo LSB. count++; after WIDTH iterations go FIX.
- FIX: if signed, negate quotient when dividend sign ≠ divisor sign; negate remainder when dividend negative. Override: div_zero → quotient all ones, remainder = original opA (no sign fix). Signed MIN/−1 needs no override: yields quotient MIN, remainder 0. Select result by op[1] into result register; go DONE.
- DONE: out_valid=1; result held stable until out_ready. On out_ready: if in_valid, accept new op same cycle (→ ITER), else → IDLE.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- flush (any state): → IDLE, out_valid=0 next cycle, no accept that cycle even if in_valid; flush has priority over accept and completion.
- Arithmetic: partial remainder WIDTH+1 bits to hold trial difference borrow; all magnitudes unsigned.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, count=0.
- Latency: acceptance edge = edge 0; out_valid rises after edge WIDTH+1 (33 for WIDTH=32), independent of operands, including divide-by-zero.
- Throughput with out_ready held high: one op per WIDTH+2 cycles.
- in_ready is combinational from state and out_ready; out_valid and result are registered.
- resetn low mid-operation: immediate return to reset values; partial op discarded.
- op/operands sampled only at acceptance; later changes ignored.

## Structure
- Package vlane_div_pkg: state enum, op bit-position constants (OP_UNSIGNED=0, OP_REM=1).
- Sub-module vlane_div_step: combinational single restoring step (rem_in, quo_in, divisor → rem_out, quo_out); instantiated once in ITER path.
- Top holds FSM, counter, sign fix-up, result register, handshake.

## Test plan
- Unsigned 100/7, op=01 → 14 (0x0000000E); op=11 → 2; out_valid exactly 33 cycles after accept.
- Signed −7/2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; 7/−2 → 0xFFFFFFFD, remainder 1.
- Divide by zero 5/0 → quotient 0xFFFFFFFF, remainder 5, same latency; signed 0x80000000/0xFFFFFFFF → quotient 0x80000000, remainder 0.
- Backpressure: out_ready low 10 cycles in DONE → result stable, in_ready=0; then out_ready+in_valid same cycle → new op accepted, next result 33 cycles later.
- flush at ITER count 15 → out_valid stays 0, in_ready=1 next cycle; following op returns correct result.
- resetn asserted mid-ITER → all outputs at reset values immediately; random signed/unsigned ops vs. reference model after release.
